fetch_stage: RTL and testbench

Instruction-fetch front end that sits directly upstream of the decode stage. Holds the architectural fetch PC and issues one instruction request at a time on the SRAM-like instruction bus. Presents `valid_o`/`pc_o` plus exception and cancel status to decode; decode itself captures `inst_rdata` on `inst_data_ok`. Branch and exception redirects are absorbed here, and in-flight fetches that a redirect has made stale are flagged as cancelled rather than aborted.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_redirect_latch.sv | 44 ++++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset PC default, AdEL code, FSM states and redirect record.
package fetch_stage_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [4:0]  EXCCODE_ADEL = 5'h04;

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_EXC, ST_HALT} fetch_state_e;

  typedef struct packed {
    logic        vld;
    logic        is_exc;
    logic [31:0] tgt;
  } redirect_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_redirect_latch.sv
// Pending redirect target and cancel flag for the in-flight fetch slot.
// merged_o is the redirect that wins this cycle (exception beats branch, pending exception beats new branch).
module fetch_redirect_latch
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_target_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  input  logic        capture_i,
  input  logic        clear_i,
  output logic        cancel_o,
  output redirect_t   merged_o
);
  redirect_t pend_q, pend_d;

  always_comb begin
    merged_o = pend_q;
    if (exc_valid_i) begin
      merged_o.vld    = 1'b1;
      merged_o.is_exc = 1'b1;
      merged_o.tgt    = exc_target_i;
    end else if (br_valid_i && !(pend_q.vld && pend_q.is_exc)) begin
      merged_o.vld    = 1'b1;
      merged_o.is_exc = 1'b0;
      merged_o.tgt    = br_target_i;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (clear_i)        pend_d = '0;
    else if (capture_i) pend_d = merged_o;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign cancel_o = pend_q.vld;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: one outstanding request, redirect absorption, stale-slot cancel.
// Optional cancelled-fetch counter enabled by defining FETCH_PERFCNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic        cancelled_o,
  output logic        exc_o,
  output logic        exc_miss_o,
  output logic [4:0]  exccode_o,
  output logic [31:0] perfcnt_fetch_cancel
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, pc_o_q, pc_o_d;
  logic         valid_q, valid_d, exc_q, exc_d, started_q;
  logic         aligned, accept, xfer, br_eff, new_redir, capture, cancel;
  redirect_t    merged;
  logic         unused_data_ok;

  assign unused_data_ok = inst_data_ok;

  assign aligned   = (pc_q[1:0] == 2'b00);
  assign inst_req  = started_q && (state_q == ST_REQ) && aligned;
  assign inst_addr = pc_q;
  assign accept    = inst_req && inst_addr_ok;
  assign xfer      = valid_q && ready_i;
  assign br_eff    = br_valid && (state_q != ST_HALT);
  assign new_redir = exc_valid || br_eff;
  assign capture   = ((state_q == ST_REQ) && accept) ||
                     (((state_q == ST_WAIT) || (state_q == ST_EXC)) && !xfer);

  fetch_redirect_latch u_redir (
    .clk         (clk),
    .resetn      (resetn),
    .exc_valid_i (exc_valid),
    .exc_target_i(exc_target),
    .br_valid_i  (br_eff),
    .br_target_i (br_target),
    .capture_i   (capture),
    .clear_i     (xfer),
    .cancel_o    (cancel),
    .merged_o    (merged)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_o_d  = pc_o_q;
    valid_d = valid_q;
    exc_d   = exc_q;
    case (state_q)
      ST_REQ: begin
        if (accept) begin
          state_d = ST_WAIT;
          valid_d = 1'b1;
          pc_o_d  = pc_q;
        end else if (new_redir) begin
          pc_d = merged.tgt;
        end else if (started_q && !aligned) begin
          state_d = ST_EXC;
          valid_d = 1'b1;
          exc_d   = 1'b1;
          pc_o_d  = pc_q;
        end
      end
      ST_WAIT, ST_EXC: begin
        if (xfer) begin
          valid_d = 1'b0;
          exc_d   = 1'b0;
          pc_o_d  = '0;
          // A redirect (pending or same-cycle) always restarts fetch, even out of an exception slot.
          if (merged.vld) begin
            pc_d    = merged.tgt;
            state_d = ST_REQ;
          end else if (state_q == ST_EXC) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = next_seq_pc(pc_q);
            state_d = ST_REQ;
          end
        end
      end
      ST_HALT: begin
        if (exc_valid) begin
          pc_d    = exc_target;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      pc_o_q    <= '0;
      valid_q   <= 1'b0;
      exc_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_o_q    <= pc_o_d;
      valid_q   <= valid_d;
      exc_q     <= exc_d;
      started_q <= 1'b1;
    end
  end

  assign valid_o     = valid_q;
  assign pc_o        = pc_o_q;
  assign cancelled_o = cancel;
  assign exc_o       = exc_q;
  assign exc_miss_o  = 1'b0;
  assign exccode_o   = exc_q ? EXCCODE_ADEL : 5'h00;

`ifdef FETCH_PERFCNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            cnt_q <= '0;
    else if (xfer && cancel && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
  end
  assign perfcnt_fetch_cancel = cnt_q;
`else
  assign perfcnt_fetch_cancel = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver runs a slot-level reference model and queues expectations,
// a negedge monitor pops and compares per-cycle status and every decode transfer.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr;
  logic        br_valid, exc_valid, ready_i;
  logic [31:0] br_target, exc_target;
  logic        valid_o, cancelled_o, exc_o, exc_miss_o;
  logic [31:0] pc_o, perfcnt_fetch_cancel;
  logic [4:0]  exccode_o;

  fetch_stage dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .br_valid(br_valid), .br_target(br_target), .exc_valid(exc_valid), .exc_target(exc_target),
    .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o), .cancelled_o(cancelled_o),
    .exc_o(exc_o), .exc_miss_o(exc_miss_o), .exccode_o(exccode_o),
    .perfcnt_fetch_cancel(perfcnt_fetch_cancel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        c;
    logic        e;
    logic        req;
    logic [31:0] addr;
    logic [31:0] cnt;
  } stat_t;
  typedef struct {
    logic [31:0] pc;
    logic        c;
    logic        e;
  } xfer_t;

  stat_t stat_q[$];
  xfer_t xfer_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: what the fetch slot holds, where fetch continues, what redirect is waiting.
  bit          m_started, m_slot, m_sexc, m_cancel, m_halt, m_pv, m_pexc;
  logic [31:0] m_pc, m_spc, m_pt, m_cnt;

  task automatic model_reset();
    m_started = 0; m_slot = 0; m_sexc = 0; m_cancel = 0; m_halt = 0; m_pv = 0; m_pexc = 0;
    m_pc = 32'hBFC0_0000; m_spc = 0; m_pt = 0; m_cnt = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit aok, input bit rdy, input bit bv_in, input logic [31:0] bt,
                            input bit ev, input logic [31:0] et);
    bit          bv, req, has_t;
    logic [31:0] t;
    xfer_t       x;
    bv  = bv_in && !m_halt;
    req = m_started && !m_slot && !m_halt && (m_pc[1:0] == 2'b00);
    if (m_halt) begin
      if (ev) begin m_pc = et; m_halt = 0; end
    end else if (!m_slot) begin
      if (ev || bv) begin
        t = ev ? et : bt;
        if (req && aok) begin
          m_slot = 1; m_spc = m_pc; m_sexc = 0; m_cancel = 1; m_pv = 1; m_pt = t; m_pexc = ev;
        end else begin
          m_pc = t;
        end
      end else if (req && aok) begin
        m_slot = 1; m_spc = m_pc; m_sexc = 0; m_cancel = 0;
      end else if (m_started && m_pc[1:0] != 2'b00) begin
        m_slot = 1; m_spc = m_pc; m_sexc = 1; m_cancel = 0;
      end
      m_started = 1;
    end else if (rdy) begin
      x.pc = m_spc; x.c = m_cancel; x.e = m_sexc;
      xfer_q.push_back(x);
`ifdef FETCH_PERFCNT_EN
      if (m_cancel && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
      has_t = 1;
      if (ev) t = et;
      else if (bv && !(m_pv && m_pexc)) t = bt;
      else if (m_pv) t = m_pt;
      else has_t = 0;
      if (has_t) m_pc = t;
      else if (m_sexc) m_halt = 1;
      else m_pc = m_pc + 32'd4;
      m_slot = 0; m_sexc = 0; m_cancel = 0; m_pv = 0; m_pexc = 0;
    end else if (ev || bv) begin
      if (ev) begin m_pt = et; m_pexc = 1; m_pv = 1; end
      else if (!(m_pv && m_pexc)) begin m_pt = bt; m_pexc = 0; m_pv = 1; end
      m_cancel = 1;
    end
  endtask

  // Called at posedge+1: drives inputs for the coming edge, queues the status expected now.
  task automatic cycle(input bit aok, input bit rdy, input bit bv = 0, input logic [31:0] bt = 0,
                       input bit ev = 0, input logic [31:0] et = 0);
    stat_t s;
    inst_addr_ok = aok; ready_i = rdy;
    br_valid = bv; br_target = bt; exc_valid = ev; exc_target = et;
    inst_data_ok = 1'($urandom_range(0, 1));
    s.v = m_slot; s.pc = m_spc; s.c = m_cancel; s.e = m_slot && m_sexc;
    s.req = m_started && !m_slot && !m_halt && (m_pc[1:0] == 2'b00);
    s.addr = m_pc; s.cnt = m_cnt;
    stat_q.push_back(s);
    model_step(aok, rdy, bv, bt, ev, et);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    stat_t s;
    xfer_t x;
    if (resetn === 1'b1) begin
      if (stat_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL stat_queue_empty t=%0t", $time);
      end else begin
        s = stat_q.pop_front();
        chk("valid_o", 32'(valid_o), 32'(s.v));
        chk("cancelled_o", 32'(cancelled_o), 32'(s.c));
        chk("exc_o", 32'(exc_o), 32'(s.e));
        chk("exccode_o", 32'(exccode_o), s.e ? 32'h4 : 32'h0);
        chk("exc_miss_o", 32'(exc_miss_o), 32'h0);
        chk("inst_req", 32'(inst_req), 32'(s.req));
        if (s.req) chk("inst_addr", inst_addr, s.addr);
        if (s.v) chk("pc_o", pc_o, s.pc);
        chk("perfcnt", perfcnt_fetch_cancel, s.cnt);
      end
      if (valid_o === 1'b1 && ready_i === 1'b1) begin
        if (xfer_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_transfer pc_o=%h t=%0t", pc_o, $time);
        end else begin
          x = xfer_q.pop_front();
          chk("xfer_pc", pc_o, x.pc);
          chk("xfer_cancel", 32'(cancelled_o), 32'(x.c));
          chk("xfer_exc", 32'(exc_o), 32'(x.e));
        end
      end
    end
  end

  initial begin
    int n;
    resetn = 0; inst_addr_ok = 0; inst_data_ok = 0; ready_i = 0;
    br_valid = 0; br_target = 0; exc_valid = 0; exc_target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'h0);
    chk("rst_inst_req", 32'(inst_req), 32'h0);
    chk("rst_cancelled_o", 32'(cancelled_o), 32'h0);
    chk("rst_perfcnt", perfcnt_fetch_cancel, 32'h0);
    resetn = 1;

    // Back-to-back sequential fetch, then a branch while the 0xBFC00010 slot waits.
    n = 0;
    while (!(m_slot && m_spc == 32'hBFC0_0010) && n < 40) begin cycle(1, 1); n++; end
    chk("reach_bfc00010", 32'(m_slot), 32'h1);
    cycle(0, 0, 1, 32'h8000_1000);
    cycle(0, 1);
    repeat (3) cycle(1, 1);
`ifdef FETCH_PERFCNT_EN
    chk("perfcnt_after_branch", perfcnt_fetch_cancel, 32'h1);
`else
    chk("perfcnt_after_branch", perfcnt_fetch_cancel, 32'h0);
`endif

    // Simultaneous branch and exception in REQ without addr_ok.
    n = 0;
    while (m_slot && n < 10) begin cycle(0, 1); n++; end
    cycle(0, 0, 1, 32'h0000_0100, 1, 32'hBFC0_0380);
    repeat (3) cycle(1, 1);

    // Misaligned exception target, AdEL slot, HALT ignores branches and addr_ok.
    n = 0;
    while (m_slot && n < 10) begin cycle(0, 1); n++; end
    cycle(0, 0, 0, 0, 1, 32'h8000_0002);
    cycle(1, 0);
    cycle(1, 0);
    cycle(1, 1);
    repeat (4) cycle(1, 1, 1, 32'h0000_2000);
    cycle(1, 1, 0, 0, 1, 32'hBFC0_0380);
    repeat (3) cycle(1, 1);

    // Asynchronous reset while a cancelled slot waits.
    n = 0;
    while (m_slot && n < 10) begin cycle(0, 1); n++; end
    cycle(1, 0);
    cycle(0, 0, 1, 32'h0000_1000);
    cycle(0, 0);
    resetn = 0;
    #1;
    chk("async_valid_o", 32'(valid_o), 32'h0);
    chk("async_cancelled_o", 32'(cancelled_o), 32'h0);
    chk("async_inst_req", 32'(inst_req), 32'h0);
    chk("async_exc_o", 32'(exc_o), 32'h0);
    chk("async_perfcnt", perfcnt_fetch_cancel, 32'h0);
    stat_q.delete(); xfer_q.delete();
    model_reset();
    inst_addr_ok = 0; ready_i = 0; br_valid = 0; exc_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1;
    repeat (3) cycle(1, 1);

    // PC wrap at the top of the address space.
    n = 0;
    while (m_slot && n < 10) begin cycle(0, 1); n++; end
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    repeat (6) cycle(1, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          ev, bv;
      logic [31:0] et, bt;
      ev = ($urandom_range(0, 99) < 3);
      bv = ($urandom_range(0, 99) < 5);
      et = $urandom();
      if ($urandom_range(0, 9) != 0) et[1:0] = 2'b00;
      if ($urandom_range(0, 19) == 0) et = 32'hFFFF_FFF8;
      bt = $urandom() & ~32'h3;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bv, bt, ev, et);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
